// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon mode controller.
// The Squeeze state exists only when ASCON_HASH_EN is defined.
package ascon_pack;

    typedef enum logic [2:0] {
        AsconOp0,
        AsconOpInit,
        AsconOpAbsorbAd,
        AsconOpDomSep,
        AsconOpAbsorbDi,
        AsconOpFinal,
        AsconOpTag,
        AsconOpSqueeze
    } ascon_op_e;

    typedef enum logic [1:0] {
        ModeEnc  = 2'b00,
        ModeDec  = 2'b01,
        ModeHash = 2'b10,
        ModeRsv  = 2'b11
    } ascon_mode_e;

    typedef enum logic [3:0] {
        StIdle,
        StDelay,
        StInit,
        StAdWait,
        StAdPerm,
        StDiWait,
        StDiPerm,
        StFinWait,
        StFinPerm,
`ifdef ASCON_HASH_EN
        StSqueeze,
`endif
        StDone,
        StError
    } ascon_state_e;

    localparam int ROUNDS_A_DEF = 12;
    localparam int ROUNDS_B_DEF = 8;
    localparam int DIGEST_BLKS  = 4;

endpackage

// File: rtl/ascon_rnd_cnt.sv
// Up-counter from zero to a loadable terminal value; last_o flags the terminal count.
module ascon_rnd_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] term_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else if (load_i) begin
            cnt_q  <= '0;
            term_q <= term_i;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == term_q);

endmodule

// File: rtl/ascon_mode_ctrl.sv
// Ascon AEAD/hash sequencing FSM: permutation rounds, block handshakes, tag and squeeze steps.
// Define ASCON_HASH_EN to enable hash mode (otherwise mode 10 is reserved).
module ascon_mode_ctrl
    import ascon_pack::*;
#(
    parameter int SIZE_WIDTH = 32,
    parameter int BLOCK_AW   = 28,
    parameter int ROUNDS_A   = ROUNDS_A_DEF,
    parameter int ROUNDS_B   = ROUNDS_B_DEF,
    parameter int DELAY_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [DELAY_W-1:0]  delay_i,
    input  logic [BLOCK_AW-1:0] ad_blks_i,
    input  logic [BLOCK_AW-1:0] di_blks_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic                tag_match_i,
    output ascon_op_e           op_o,
    output logic                en_state_o,
    output logic                sel_ad_o,
    output logic                en_padding_o,
    output logic                en_buf_out_o,
    output logic                en_tag_o,
    output logic [3:0]          rnd_idx_o,
    output logic                idle_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                tag_ok_o,
    output logic                err_o
);

    localparam logic [3:0]          TermA  = 4'(ROUNDS_A - 1);
    localparam logic [3:0]          TermB  = 4'(ROUNDS_B - 1);
    localparam logic [BLOCK_AW-1:0] OneBlk = BLOCK_AW'(1);

    ascon_state_e        state_q, state_d;
    ascon_mode_e         mode_q, mode_d;
    logic [BLOCK_AW-1:0] adCnt_q, adCnt_d, diCnt_q, diCnt_d;
    logic                tagOk_q, tagOk_d, tagPend_q, tagPend_d, relPend_q, relPend_d;
    logic                rndLoad, rndEn, rndLast, dlyLoad, dlyEn, dlyLast;
    logic [3:0]          rndTerm, rndCnt;
    logic [DELAY_W-1:0]  dlyCnt;
    logic                modeRsv, isHash, lastDi;

`ifdef ASCON_HASH_EN
    localparam int SqW = $clog2(DIGEST_BLKS);
    logic [SqW-1:0] sqCnt_q, sqCnt_d;
    assign modeRsv = (mode_i == ModeRsv);
`else
    assign modeRsv = mode_i[1];
`endif

    assign isHash = (mode_q == ModeHash);
    assign lastDi = (diCnt_q <= OneBlk);

    ascon_rnd_cnt #(.W(4)) uRndCnt (
        .clk(clk), .rst(rst), .load_i(rndLoad), .en_i(rndEn),
        .term_i(rndTerm), .cnt_o(rndCnt), .last_o(rndLast)
    );

    ascon_rnd_cnt #(.W(DELAY_W)) uDlyCnt (
        .clk(clk), .rst(rst), .load_i(dlyLoad), .en_i(dlyEn),
        .term_i(delay_i), .cnt_o(dlyCnt), .last_o(dlyLast)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        adCnt_d      = adCnt_q;
        diCnt_d      = diCnt_q;
        tagOk_d      = tagOk_q;
        tagPend_d    = 1'b0;
        relPend_d    = 1'b0;
        rndLoad      = 1'b0;
        rndEn        = 1'b0;
        rndTerm      = TermA;
        dlyLoad      = 1'b0;
        dlyEn        = 1'b0;
        op_o         = AsconOp0;
        en_state_o   = 1'b0;
        sel_ad_o     = 1'b0;
        en_padding_o = 1'b0;
        en_buf_out_o = 1'b0;
        en_tag_o     = 1'b0;
        data_ready_o = 1'b0;
`ifdef ASCON_HASH_EN
        sqCnt_d      = sqCnt_q;
`endif
        case (state_q)
            StIdle: if (start_i) begin
                tagOk_d = 1'b0;
                mode_d  = ascon_mode_e'(mode_i);
                adCnt_d = ad_blks_i;
                diCnt_d = di_blks_i;
                if (modeRsv) begin
                    state_d = StError;
                end else begin
                    state_d = StDelay;
                    dlyLoad = 1'b1;
                end
            end
            StDelay: begin
                dlyEn = !dlyLast;
                if (dlyLast) begin
                    state_d = StInit;
                    rndLoad = 1'b1;
                end
            end
            StInit: begin
                op_o       = AsconOpInit;
                en_state_o = 1'b1;
                rndEn      = 1'b1;
                if (rndLast) begin
                    if (adCnt_q != '0 && !isHash) state_d = StAdWait;
                    else state_d = lastDi ? StFinWait : StDiWait;
                end
            end
            // Wait states abort on start_i low; otherwise each accepted block starts a permutation.
            StAdWait: begin
                op_o         = AsconOpAbsorbAd;
                data_ready_o = 1'b1;
                sel_ad_o     = 1'b1;
                en_padding_o = (adCnt_q == OneBlk);
                if (!start_i) begin
                    state_d = StIdle;
                end else if (data_valid_i) begin
                    adCnt_d = adCnt_q - OneBlk;
                    state_d = StAdPerm;
                    rndLoad = 1'b1;
                    rndTerm = TermB;
                end
            end
            StAdPerm: begin
                en_state_o = 1'b1;
                rndEn      = 1'b1;
                if (rndLast) begin
                    if (adCnt_q == '0) begin
                        op_o    = AsconOpDomSep;
                        state_d = lastDi ? StFinWait : StDiWait;
                    end else begin
                        state_d = StAdWait;
                    end
                end
            end
            StDiWait: begin
                op_o         = AsconOpAbsorbDi;
                data_ready_o = 1'b1;
                if (!start_i) begin
                    state_d = StIdle;
                end else if (data_valid_i) begin
                    en_buf_out_o = 1'b1;
                    diCnt_d      = diCnt_q - OneBlk;
                    state_d      = StDiPerm;
                    rndLoad      = 1'b1;
                    rndTerm      = isHash ? TermA : TermB;
                end
            end
            StDiPerm: begin
                en_state_o = 1'b1;
                rndEn      = 1'b1;
                if (rndLast) state_d = lastDi ? StFinWait : StDiWait;
            end
            // Decrypted final block is held back until the tag has been checked.
            StFinWait: begin
                op_o         = AsconOpFinal;
                data_ready_o = 1'b1;
                if (!start_i) begin
                    state_d = StIdle;
                end else if (data_valid_i) begin
                    en_buf_out_o = (mode_q != ModeDec);
                    diCnt_d      = diCnt_q - OneBlk;
                    state_d      = StFinPerm;
                    rndLoad      = 1'b1;
                end
            end
            StFinPerm: begin
                en_state_o = 1'b1;
                rndEn      = 1'b1;
                if (rndLast) begin
`ifdef ASCON_HASH_EN
                    if (isHash) begin
                        state_d = StSqueeze;
                        sqCnt_d = SqW'(DIGEST_BLKS - 1);
                    end else begin
                        state_d   = StDone;
                        tagPend_d = 1'b1;
                    end
`else
                    state_d   = StDone;
                    tagPend_d = 1'b1;
`endif
                end
            end
`ifdef ASCON_HASH_EN
            StSqueeze: begin
                op_o         = AsconOpSqueeze;
                en_buf_out_o = 1'b1;
                if (sqCnt_q != '0) begin
                    sqCnt_d = sqCnt_q - SqW'(1);
                    state_d = StFinPerm;
                    rndLoad = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
`endif
            // First Done cycle after an AEAD run is the tag cycle; done_o follows it.
            StDone: begin
                en_buf_out_o = relPend_q;
                if (tagPend_q) begin
                    op_o      = AsconOpTag;
                    en_tag_o  = 1'b1;
                    tagOk_d   = (mode_q == ModeDec) ? tag_match_i : 1'b1;
                    relPend_d = (mode_q == ModeDec) && tag_match_i;
                end else if (!start_i) begin
                    state_d = StIdle;
                end
            end
            StError: if (!start_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= ModeEnc;
            adCnt_q   <= '0;
            diCnt_q   <= '0;
            tagOk_q   <= 1'b0;
            tagPend_q <= 1'b0;
            relPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            adCnt_q   <= adCnt_d;
            diCnt_q   <= diCnt_d;
            tagOk_q   <= tagOk_d;
            tagPend_q <= tagPend_d;
            relPend_q <= relPend_d;
        end
    end

`ifdef ASCON_HASH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sqCnt_q <= '0;
        else     sqCnt_q <= sqCnt_d;
    end
`endif

    assign rnd_idx_o = en_state_o ? rndCnt : 4'd0;
    assign idle_o    = (state_q == StIdle);
    assign busy_o    = !(state_q == StIdle || state_q == StDone || state_q == StError);
    assign done_o    = (state_q == StDone) && !tagPend_q;
    assign tag_ok_o  = tagOk_q;
    assign err_o     = (state_q == StError);

endmodule

// File: doc/ascon_mode_ctrl.md
ASCON_MODE_CTRL -- requirements
Module: ascon_mode_ctrl

Interface
REQ-001 SHALL have parameter SIZE_WIDTH, default 32, byte-count width of AD/data sizes.
REQ-002 SHALL have parameter BLOCK_AW, default 28, width of block counters.
REQ-003 SHALL have parameter ROUNDS_A, default 12, rounds for init/final/hash permutations.
REQ-004 SHALL have parameter ROUNDS_B, default 8, rounds for AEAD AD/data permutations.
REQ-005 SHALL have parameter DELAY_W, default 8, width of start-delay counter.
REQ-006 SHALL have ports: clk  in  1  clock (rising edge); rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: start_i  in  1  run enable, level; mode_i  in  2  00 encrypt, 01 decrypt, 10 hash, 11 reserved; delay_i  in  DELAY_W  start delay cycles.
REQ-008 SHALL have ports: ad_blks_i  in  BLOCK_AW  AD blocks incl. padded last (0 = no AD); di_blks_i  in  BLOCK_AW  data blocks incl. padded last (min 1).
REQ-009 SHALL have ports: data_valid_i  in  1; data_ready_o  out  1; tag_match_i  in  1  external tag comparator result.
REQ-010 SHALL have ports: op_o  out  ascon_op_e; en_state_o, sel_ad_o, en_padding_o, en_buf_out_o, en_tag_o  out  1 each; rnd_idx_o  out  4  current round index.
REQ-011 SHALL have ports: idle_o, busy_o, done_o, tag_ok_o, err_o  out  1 each.

Function
REQ-012 States: Idle, Delay, Init, AdWait, AdPerm, DiWait, DiPerm, FinWait, FinPerm, Squeeze, Done, Error.
REQ-013 Idle->Delay on start_i; Delay loads delay_i into counter, decrements, ->Init when zero (delay_i=0 gives one Delay cycle).
REQ-014 mode_i sampled on Idle->Delay; mode 11 -> Error; Error holds err_o=1 until start_i low, then Idle.
REQ-015 Init: ROUNDS_A rounds; then AdWait if ad_blks_i!=0 and not hash, else DiWait.
REQ-016 Internal round counter loaded with ROUNDS_A or ROUNDS_B on each Perm entry; rnd_idx_o counts 0..N-1; en_state_o=1 every round cycle; exit exactly after N cycles.
REQ-017 Wait states: data_ready_o=1; transfer when data_valid_i&data_ready_o; block counter decremented per transfer.
REQ-018 AdPerm after last AD block: en_padding_o on last block, op_o=domain-separation op on exit, -> DiWait.
REQ-019 Data path: non-last blocks via DiPerm (ROUNDS_B; hash ROUNDS_A); last block -> FinWait then FinPerm (ROUNDS_A), en_buf_out_o=1 on each data transfer cycle.
REQ-020 Encrypt: FinPerm exit -> one cycle en_tag_o=1 -> Done, tag_ok_o=1.
REQ-021 Decrypt: FinPerm exit -> en_tag_o=1, tag_match_i sampled that cycle into tag_ok_o; en_buf_out_o suppressed for final-block output when TAG_GATE applies (REQ-030).
REQ-022 Hash: after FinPerm, Squeeze emits 4 digest blocks; ROUNDS_A permutation between blocks, none after fourth; en_buf_out_o=1 per emitted block.
REQ-023 Any Wait state with start_i=0 -> Idle next cycle; Perm states complete their rounds before honouring start_i=0.
REQ-024 Done holds done_o, tag_ok_o until start_i=0, then Idle; tag_ok_o cleared on Idle exit.
REQ-025 idle_o=1 only in Idle; busy_o=1 in all states except Idle, Done, Error.
REQ-026 All outputs Moore-decoded from state/counters; data_ready_o shall not depend combinationally on data_valid_i.

Reset
REQ-027 rst asserted: state Idle, all counters 0, tag_ok_o=0, err_o=0, op_o=AsconOp0, all enables 0, idle_o=1.
REQ-028 rst mid-permutation aborts immediately; first cycle after release is Idle.

Configuration
REQ-029 Macro ASCON_HASH_EN: defined -> hash mode per REQ-022; undefined -> mode 10 treated as reserved (Error), Squeeze state and its counter absent.
REQ-030 Decrypt plaintext release always gated: en_buf_out_o on decrypt asserted only for non-final blocks; final block released only with tag_ok_o=1 (not configurable).

Structure
REQ-031 ascon_op_e, mode enum, ROUNDS defaults, digest block count (4) belong in ascon_pack.
REQ-032 Round/block/delay counting in sub-module ascon_rnd_cnt (load, enable, last flag), instantiated for rounds; FSM in top.

Verification
REQ-033 Encrypt, ad_blks_i=2, di_blks_i=3, delay_i=0 -> 12+8+8+8+8+12 round cycles, done_o=1, tag_ok_o=1.
REQ-034 Decrypt, ad_blks_i=0, di_blks_i=1, tag_match_i=0 -> AdWait skipped, done_o=1, tag_ok_o=0, no final en_buf_out_o.
REQ-035 Hash (ASCON_HASH_EN), di_blks_i=2 -> four en_buf_out_o squeeze pulses, three 12-round permutations between them.
REQ-036 mode_i=11 -> err_o=1, no en_state_o pulse; start_i low -> Idle, err_o=0.
REQ-037 start_i dropped in DiWait -> Idle next cycle; rst pulse at round 5 of Init -> Idle, all outputs reset values.
